// File: rtl/relu_backprop_if.sv
// Gradient stream bundle for relu_backprop: upstream gradient in, masked gradient out.
// Valid/ready: a word moves on a rising edge where valid && ready; the sender holds data stable while valid && !ready.
interface relu_backprop_if #(
  parameter int PX_SIZE = 8
);
  logic [PX_SIZE-1:0] grad_in;
  logic               grad_in_valid;
  logic               grad_in_ready;
  logic [PX_SIZE-1:0] grad_out;
  logic               grad_out_valid;
  logic               grad_out_ready;
  logic               grad_out_last;

  modport slave (
    input  grad_in, grad_in_valid, grad_out_ready,
    output grad_in_ready, grad_out, grad_out_valid, grad_out_last
  );

  modport master (
    output grad_in, grad_in_valid, grad_out_ready,
    input  grad_in_ready, grad_out, grad_out_valid, grad_out_last
  );
endinterface

// File: rtl/relu_backprop.sv
// ReLU backward pass: latch a positive-pixel mask from a full frame, then pass or zero
// each raster-ordered gradient through a single output register stage.
module relu_backprop #(
  parameter int INPUT_SIZE = 5,
  parameter int PX_SIZE    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [INPUT_SIZE-1:0][INPUT_SIZE-1:0][PX_SIZE-1:0] frame_in,
  input  logic frame_valid,
  output logic mask_valid,
  output logic done,
  output logic [1:0] state_o,
  relu_backprop_if.slave gbus
);
  localparam int N  = INPUT_SIZE * INPUT_SIZE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_STREAM = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       mask_q, mask_d, mask_new;
  logic [KW-1:0]      k_q, k_d;
  logic [PX_SIZE-1:0] out_q, out_d;
  logic               ov_q, ov_d;
  logic               last_q, last_d;
  logic               done_q, done_d;
  logic               ready, accept, at_last, capture;

  always_comb begin
    mask_new = '0;
    for (int r = 0; r < INPUT_SIZE; r++) begin
      for (int c = 0; c < INPUT_SIZE; c++) begin
        mask_new[r*INPUT_SIZE + c] = ($signed(frame_in[r][c]) > 0);
      end
    end
  end

  assign ready   = (state_q != S_IDLE) && (!ov_q || gbus.grad_out_ready);
  assign accept  = gbus.grad_in_valid && ready;
  assign at_last = (k_q == KW'(N - 1));
  // A capture racing the first accept in ARMED loses: the mask that pixel used must stay in force.
  assign capture = frame_valid &&
                   ((state_q == S_IDLE) || (state_q == S_ARMED && !accept) || (accept && at_last));

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    k_d     = k_q;
    out_d   = out_q;
    last_d  = last_q;
    ov_d    = ov_q;
    done_d  = 1'b0;
    if (accept) begin
      out_d   = mask_q[k_q] ? gbus.grad_in : '0;
      last_d  = at_last;
      ov_d    = 1'b1;
      done_d  = at_last;
      k_d     = at_last ? '0 : k_q + KW'(1);
      state_d = at_last ? S_IDLE : S_STREAM;
    end else if (gbus.grad_out_ready) begin
      ov_d = 1'b0;
    end
    if (capture) begin
      mask_d  = mask_new;
      state_d = S_ARMED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      k_q     <= '0;
      out_q   <= '0;
      last_q  <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      k_q     <= k_d;
      out_q   <= out_d;
      last_q  <= last_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
    end
  end

  assign mask_valid          = (state_q != S_IDLE);
  assign done                = done_q;
  assign state_o             = state_q;
  assign gbus.grad_in_ready  = ready;
  assign gbus.grad_out       = out_q;
  assign gbus.grad_out_valid = ov_q;
  assign gbus.grad_out_last  = last_q;
endmodule

// File: tb/tb_relu_backprop.sv
// Bench for relu_backprop: directed frames from the test plan plus random traffic,
// checked every cycle against a pixel-count/mask model and an expected-output queue.
module tb_relu_backprop;
  localparam int S  = 5;
  localparam int PX = 8;
  localparam int N  = S * S;

  typedef logic [S-1:0][S-1:0][PX-1:0] frame_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  frame_t frame_in = '0;
  logic   frame_valid = 1'b0;
  logic   mask_valid, done;
  logic [1:0] state_o;

  relu_backprop_if #(.PX_SIZE(PX)) bus ();

  relu_backprop #(.INPUT_SIZE(S), .PX_SIZE(PX)) dut (
    .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .frame_valid(frame_valid),
    .mask_valid(mask_valid), .done(done), .state_o(state_o), .gbus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [PX-1:0] exp_q[$];
  logic [PX-1:0] out_log[$];
  logic          last_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: whether a mask is held, how many pixels of the frame were taken,
  // and what the single output slot shows.
  logic          m_held = 1'b0;
  logic          m_mask[N];
  int            m_taken = 0;
  logic          m_ov = 1'b0, m_ol = 1'b0, m_done = 1'b0;
  logic [PX-1:0] m_od = '0;

  always @(negedge clk) begin
    logic exp_ready, acc, fin, take;
    if (!rst_n) begin
      m_held = 1'b0; m_taken = 0; m_ov = 1'b0; m_ol = 1'b0; m_od = '0; m_done = 1'b0;
      foreach (m_mask[i]) m_mask[i] = 1'b0;
      exp_q.delete();
      check("rst_mask_valid", mask_valid, 0);
      check("rst_in_ready", bus.grad_in_ready, 0);
      check("rst_out_valid", bus.grad_out_valid, 0);
      check("rst_out", bus.grad_out, 0);
      check("rst_last", bus.grad_out_last, 0);
      check("rst_done", done, 0);
    end else begin
      exp_ready = m_held && (!m_ov || bus.grad_out_ready);
      check("mask_valid", mask_valid, m_held);
      check("grad_in_ready", bus.grad_in_ready, exp_ready);
      check("grad_out_valid", bus.grad_out_valid, m_ov);
      check("done", done, m_done);
      if (m_ov) begin
        check("grad_out", bus.grad_out, m_od);
        check("grad_out_last", bus.grad_out_last, m_ol);
      end
      if (done) done_cnt++;
      if (bus.grad_out_valid && bus.grad_out_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected", 1, 0);
        else check("sb_data", bus.grad_out, exp_q.pop_front());
        out_log.push_back(bus.grad_out);
        last_log.push_back(bus.grad_out_last);
      end
      // Advance the model to what the next rising edge must produce.
      acc  = bus.grad_in_valid && exp_ready;
      fin  = acc && (m_taken == N - 1);
      take = frame_valid && (!m_held || (m_taken == 0 && !acc) || fin);
      m_done = fin;
      if (acc) begin
        m_od = m_mask[m_taken] ? bus.grad_in : '0;
        m_ol = (m_taken == N - 1);
        m_ov = 1'b1;
        exp_q.push_back(m_od);
        m_taken = fin ? 0 : m_taken + 1;
      end else if (bus.grad_out_ready) begin
        m_ov = 1'b0;
      end
      if (fin) m_held = 1'b0;
      if (take) begin
        m_held = 1'b1;
        for (int r = 0; r < S; r++)
          for (int c = 0; c < S; c++)
            m_mask[r*S + c] = ($signed(frame_in[r][c]) > 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic frame_t checker_frame();
    frame_t f;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++)
        f[r][c] = ((r + c) % 2 == 0) ? 8'sd5 : -8'sd5;
    return f;
  endfunction

  function automatic frame_t fill_frame(input logic [PX-1:0] v);
    frame_t f;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++)
        f[r][c] = v;
    return f;
  endfunction

  task automatic capture(input frame_t f);
    frame_in = f;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic push_grad(input logic [PX-1:0] g);
    int n = 0;
    bus.grad_in = g;
    bus.grad_in_valid = 1'b1;
    @(negedge clk);
    while (!bus.grad_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("push_timeout", (n >= 50), 0);
    tick();
    bus.grad_in_valid = 1'b0;
  endtask

  task automatic start_log();
    out_log.delete();
    last_log.delete();
    done_cnt = 0;
  endtask

  task automatic check_counting(input string name, input bit parity);
    check({name, "_count"}, out_log.size(), N);
    for (int i = 0; i < N; i++) begin
      check({name, "_data"}, out_log[i], (parity && (i % 2 == 1)) ? 0 : i + 1);
      check({name, "_last"}, last_log[i], (i == N - 1));
    end
    check({name, "_done"}, done_cnt, 1);
  endtask

  task automatic blocked_probe(input string name);
    bus.grad_in_valid = 1'b1;
    bus.grad_in = 8'h33;
    repeat (3) begin
      @(negedge clk);
      check({name, "_ready"}, bus.grad_in_ready, 0);
      check({name, "_ovalid"}, bus.grad_out_valid, 0);
    end
    tick();
    bus.grad_in_valid = 1'b0;
  endtask

  initial begin
    frame_t f;
    bus.grad_in = '0;
    bus.grad_in_valid = 1'b0;
    bus.grad_out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    blocked_probe("precap");

    // Checkerboard: odd pixels zeroed, one pixel per cycle.
    start_log();
    capture(checker_frame());
    for (int i = 0; i < N; i++) push_grad(PX'(i + 1));
    repeat (3) tick();
    check_counting("checker", 1'b1);

    // Signed boundary values on the first four pixels.
    start_log();
    f = fill_frame(8'h01);
    f[0][0] = 8'h00; f[0][1] = 8'h80; f[0][2] = 8'h7F; f[0][3] = 8'h01;
    capture(f);
    for (int i = 0; i < N; i++) push_grad(8'h55);
    repeat (3) tick();
    check("bnd_0", out_log[0], 8'h00);
    check("bnd_1", out_log[1], 8'h00);
    check("bnd_2", out_log[2], 8'h55);
    check("bnd_3", out_log[3], 8'h55);

    // Backpressure at k=10 and an ignored capture at k=12 in one frame.
    start_log();
    capture(checker_frame());
    for (int i = 0; i < N; i++) begin
      if (i == 12) begin
        frame_in = fill_frame(8'hF0);
        frame_valid = 1'b1;
      end
      push_grad(PX'(i + 1));
      frame_valid = 1'b0;
      if (i == 10) begin
        check("stall_holds_k10", bus.grad_out, 8'd11);
        fork
          begin
            bus.grad_out_ready = 1'b0;
            repeat (3) tick();
            bus.grad_out_ready = 1'b1;
          end
        join_none
      end
    end
    repeat (3) tick();
    check_counting("stall_ignore", 1'b1);

    // Re-capture while armed replaces the mask.
    start_log();
    capture(checker_frame());
    capture(fill_frame(8'h01));
    for (int i = 0; i < N; i++) push_grad(PX'(i + 1));
    repeat (3) tick();
    check_counting("recapture", 1'b0);

    // Capture coincident with the final accept re-arms.
    capture(checker_frame());
    for (int i = 0; i < N - 1; i++) push_grad(PX'(i + 1));
    frame_in = fill_frame(8'h01);
    frame_valid = 1'b1;
    push_grad(PX'(N));
    frame_valid = 1'b0;
    check("coinc_mask_valid", mask_valid, 1);
    check("coinc_armed", state_o, 2'd1);
    tick();
    start_log();
    for (int i = 0; i < N; i++) push_grad(PX'(i + 1));
    repeat (3) tick();
    check_counting("coinc_next", 1'b0);

    // Reset in the middle of a frame.
    capture(checker_frame());
    for (int i = 0; i < 7; i++) push_grad(PX'(i + 1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", bus.grad_out, 0);
    check("mid_rst_ovalid", bus.grad_out_valid, 0);
    check("mid_rst_mask_valid", mask_valid, 0);
    check("mid_rst_ready", bus.grad_in_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", state_o, 2'd0);
    blocked_probe("post_rst");
    start_log();
    capture(checker_frame());
    for (int i = 0; i < N; i++) push_grad(PX'(i + 1));
    repeat (3) tick();
    check_counting("post_rst_frame", 1'b1);

    // Random traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.grad_in_valid  = ($urandom_range(0, 3) != 0);
      bus.grad_in        = PX'($urandom);
      bus.grad_out_ready = ($urandom_range(0, 3) != 0);
      frame_valid        = ($urandom_range(0, 19) == 0);
      for (int r = 0; r < S; r++)
        for (int c = 0; c < S; c++)
          frame_in[r][c] = PX'($urandom);
      tick();
    end
    bus.grad_in_valid = 1'b0;
    bus.grad_out_ready = 1'b1;
    frame_valid = 1'b0;
    repeat (4) tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
